// File: rtl/dadda_mult_pipe.sv
// Three-stage pipelined Dadda multiplier, unsigned or Baugh-Wooley signed per transaction.
// Define DADDA_MULT_TAG_EN to add an in_tag/out_tag sideband that travels with each product.
module dadda_mult_pipe #(
    parameter int WIDTH = 8
`ifdef DADDA_MULT_TAG_EN
    ,
    parameter int TAG_W = 4
`endif
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_signed,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_product
`ifdef DADDA_MULT_TAG_EN
    ,
    input  logic [TAG_W-1:0]     in_tag,
    output logic [TAG_W-1:0]     out_tag
`endif
);

    localparam int NCOL = 2 * WIDTH;
    localparam int MAXH = WIDTH + 1;
    localparam int Heights [8] = '{2, 3, 4, 6, 9, 13, 19, 28};

    // Returns {row1, row0}. The constant-one slots are always present so column
    // heights, and hence the adder network, do not depend on the mode bit.
    function automatic logic [2*NCOL-1:0] dadda_reduce(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic             sgn
    );
        logic              col  [NCOL][MAXH];
        logic              nxt  [NCOL][MAXH];
        int                cnt  [NCOL];
        int                ncnt [NCOL];
        int                d;
        int                idx;
        int                h;
        logic              pp;
        logic              x;
        logic              y;
        logic              z;
        logic              sum;
        logic              carry;
        logic [2*NCOL-1:0] rows;
        for (int c = 0; c < NCOL; c++) begin
            cnt[c] = 0;
            for (int r = 0; r < MAXH; r++) col[c][r] = 1'b0;
        end
        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j < WIDTH; j++) begin
                pp = a[i] & b[j];
                if (sgn && ((i == WIDTH - 1) != (j == WIDTH - 1))) pp = ~pp;
                col[i+j][cnt[i+j]] = pp;
                cnt[i+j]++;
            end
        end
        col[WIDTH][cnt[WIDTH]] = sgn;
        cnt[WIDTH]++;
        col[NCOL-1][cnt[NCOL-1]] = sgn;
        cnt[NCOL-1]++;

        for (int s = 7; s >= 0; s--) begin
            d = Heights[s];
            for (int c = 0; c < NCOL; c++) begin
                ncnt[c] = 0;
                for (int r = 0; r < MAXH; r++) nxt[c][r] = 1'b0;
            end
            for (int c = 0; c < NCOL; c++) begin
                idx = 0;
                // Carries already pushed in from column c-1 count toward this column's height.
                h = cnt[c] + ncnt[c];
                for (int k = 0; k < MAXH; k++) begin
                    if (h > d && cnt[c] - idx >= 2) begin
                        x = col[c][idx];
                        y = col[c][idx+1];
                        if (h == d + 1 || cnt[c] - idx == 2) begin
                            sum   = x ^ y;
                            carry = x & y;
                            idx   = idx + 2;
                            h     = h - 1;
                        end else begin
                            z     = col[c][idx+2];
                            sum   = x ^ y ^ z;
                            carry = (x & y) | (x & z) | (y & z);
                            idx   = idx + 3;
                            h     = h - 2;
                        end
                        nxt[c][ncnt[c]] = sum;
                        ncnt[c]++;
                        if (c + 1 < NCOL) begin
                            nxt[c+1][ncnt[c+1]] = carry;
                            ncnt[c+1]++;
                        end
                    end
                end
                for (int k = 0; k < MAXH; k++) begin
                    if (k >= idx && k < cnt[c]) begin
                        nxt[c][ncnt[c]] = col[c][k];
                        ncnt[c]++;
                    end
                end
            end
            col = nxt;
            cnt = ncnt;
        end

        for (int c = 0; c < NCOL; c++) begin
            rows[c]        = col[c][0];
            rows[NCOL + c] = col[c][1];
        end
        return rows;
    endfunction

    logic              v1_q, v2_q, v3_q;
    logic [WIDTH-1:0]  a_q, b_q;
    logic              sgn_q;
    logic [NCOL-1:0]   row0_q, row1_q;
    logic [NCOL-1:0]   prod_q;
    logic [2*NCOL-1:0] rows_d;
    logic              advance;
`ifdef DADDA_MULT_TAG_EN
    logic [TAG_W-1:0]  tag1_q, tag2_q, tag3_q;
`endif

    always_comb begin
        advance = !(v3_q && !out_ready);
        rows_d  = dadda_reduce(a_q, b_q, sgn_q);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            v3_q   <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            sgn_q  <= 1'b0;
            row0_q <= '0;
            row1_q <= '0;
            prod_q <= '0;
`ifdef DADDA_MULT_TAG_EN
            tag1_q <= '0;
            tag2_q <= '0;
            tag3_q <= '0;
`endif
        end else if (advance) begin
            v1_q <= in_valid;
            v2_q <= v1_q;
            v3_q <= v2_q;
            if (in_valid) begin
                a_q   <= in_a;
                b_q   <= in_b;
                sgn_q <= in_signed;
`ifdef DADDA_MULT_TAG_EN
                tag1_q <= in_tag;
`endif
            end
            if (v1_q) begin
                row0_q <= rows_d[NCOL-1:0];
                row1_q <= rows_d[2*NCOL-1:NCOL];
`ifdef DADDA_MULT_TAG_EN
                tag2_q <= tag1_q;
`endif
            end
            // Only real results load, so the output holds its last value across bubbles.
            if (v2_q) begin
                prod_q <= row0_q + row1_q;
`ifdef DADDA_MULT_TAG_EN
                tag3_q <= tag2_q;
`endif
            end
        end
    end

    assign in_ready    = advance;
    assign out_valid   = v3_q;
    assign out_product = prod_q;
`ifdef DADDA_MULT_TAG_EN
    assign out_tag     = tag3_q;
`endif

endmodule

// File: tb/tb_dadda_mult_pipe.sv
// Bench for dadda_mult_pipe (WIDTH=8): directed corners plus random traffic against an
// arithmetic reference; tag checks are compiled in when DADDA_MULT_TAG_EN is defined.
module tb_dadda_mult_pipe;

    localparam int W = 8;

    logic           clock;
    logic           reset_n;
    logic           in_valid;
    logic           in_ready;
    logic           in_signed;
    logic [W-1:0]   in_a;
    logic [W-1:0]   in_b;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] out_product;
`ifdef DADDA_MULT_TAG_EN
    logic [3:0]     in_tag;
    logic [3:0]     out_tag;
`endif

    typedef struct {
        logic [2*W-1:0] prod;
        logic [3:0]     tag;
    } exp_t;

    exp_t           exp_q [$];
    logic [3:0]     tag_seen [$];
    int             checks;
    int             errors;
    int             n_out;
    int             run;
    int             max_run;
    logic           holding;
    logic [2*W-1:0] held;

    dadda_mult_pipe #(
        .WIDTH(W)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_signed  (in_signed),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_product(out_product)
`ifdef DADDA_MULT_TAG_EN
        ,
        .in_tag     (in_tag),
        .out_tag    (out_tag)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic s);
        longint x;
        longint y;
        longint p;
        if (s) begin
            x = longint'($signed(a));
            y = longint'($signed(b));
        end else begin
            x = longint'(a);
            y = longint'(b);
        end
        p = x * y;
        return p[2*W-1:0];
    endfunction

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", name, obs, expv);
        end
    endtask

    // Samples the handshake mid-cycle, then advances to 1 time unit past the next rising edge.
    task automatic step();
        exp_t e;
        @(negedge clock);
        if (!reset_n) begin
            exp_q.delete();
            holding = 1'b0;
        end else begin
            if (out_valid) begin
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
            if (out_valid && !out_ready) begin
                if (holding) check("stall_hold", out_product, held);
                else begin
                    held    = out_product;
                    holding = 1'b1;
                end
            end else begin
                holding = 1'b0;
            end
            if (out_valid && out_ready) begin
                check("out_has_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("product", out_product, e.prod);
`ifdef DADDA_MULT_TAG_EN
                    check("tag", out_tag, e.tag);
                    tag_seen.push_back(out_tag);
`endif
                    n_out++;
                end
            end
            if (in_valid && in_ready) begin
                e.prod = ref_mul(in_a, in_b, in_signed);
`ifdef DADDA_MULT_TAG_EN
                e.tag = in_tag;
`else
                e.tag = 4'h0;
`endif
                exp_q.push_back(e);
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic corner(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s, input logic [2*W-1:0] expc);
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_signed = s;
        step();
        in_valid = 1'b0;
        step();
        step();
        check({name, "_valid"}, out_valid, 1);
        check(name, out_product, expc);
        step();
    endtask

    initial begin
        int n0;
        logic [2*W-1:0] snap;
        checks = 0; errors = 0; n_out = 0; run = 0; max_run = 0;
        holding = 1'b0; held = '0;
        reset_n = 1'b0; in_valid = 1'b0; in_signed = 1'b0;
        in_a = '0; in_b = '0; out_ready = 1'b1;
`ifdef DADDA_MULT_TAG_EN
        in_tag = 4'h0;
`endif
        step();
        step();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_product", out_product, 0);
        check("rst_in_ready", in_ready, 1);
        reset_n = 1'b1;

        // Latency: capture edge plus two more edges.
        in_valid = 1'b1; in_a = 8'h05; in_b = 8'h0C; in_signed = 1'b0;
        step();
        in_valid = 1'b0;
        check("lat_edge0_valid", out_valid, 0);
        step();
        check("lat_edge1_valid", out_valid, 0);
        step();
        check("lat_valid", out_valid, 1);
        check("lat_product", out_product, 16'h003C);
        step();
        check("bubble_valid", out_valid, 0);
        check("bubble_hold", out_product, 16'h003C);

        corner("u_ff_ff", 8'hFF, 8'hFF, 1'b0, 16'hFE01);
        corner("s_ff_02", 8'hFF, 8'h02, 1'b1, 16'hFFFE);
        corner("s_80_80", 8'h80, 8'h80, 1'b1, 16'h4000);
        corner("s_80_7f", 8'h80, 8'h7F, 1'b1, 16'hC080);

        // Back-to-back random mixed-mode stream.
        n0 = n_out; run = 0; max_run = 0;
        for (int i = 0; i < 10; i++) begin
            in_valid  = 1'b1;
            in_a      = W'($urandom);
            in_b      = W'($urandom);
            in_signed = 1'($urandom_range(0, 1));
            step();
        end
        in_valid = 1'b0;
        repeat (5) step();
        check("stream_count", n_out - n0, 10);
        check("stream_consecutive", max_run, 10);

        // Backpressure with three items in flight and a fourth waiting.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid  = 1'b1;
            in_a      = W'($urandom);
            in_b      = W'($urandom);
            in_signed = 1'($urandom_range(0, 1));
            step();
        end
        in_a = W'($urandom); in_b = W'($urandom); in_signed = 1'b1;
        #1;
        check("stall_in_ready", in_ready, 0);
        check("stall_out_valid", out_valid, 1);
        snap = out_product;
        repeat (5) begin
            step();
            check("stall_in_ready_hold", in_ready, 0);
        end
        check("stall_prod_stable", out_product, snap);
        n0 = n_out; run = 0; max_run = 0;
        out_ready = 1'b1;
        #1;
        check("release_in_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        repeat (6) step();
        check("release_count", n_out - n0, 4);
        check("release_consecutive", max_run, 4);

        // Reset with two items in flight discards both.
        for (int i = 0; i < 2; i++) begin
            in_valid  = 1'b1;
            in_a      = W'($urandom_range(1, 255));
            in_b      = W'($urandom_range(1, 255));
            in_signed = 1'b0;
            step();
        end
        in_valid = 1'b0;
        reset_n  = 1'b0;
        step();
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_product", out_product, 0);
        reset_n = 1'b1;
        n0 = n_out;
        repeat (6) step();
        check("midrst_no_emit", n_out - n0, 0);

`ifdef DADDA_MULT_TAG_EN
        tag_seen.delete();
        in_valid = 1'b1; in_signed = 1'b0;
        in_a = 8'h11; in_b = 8'h03; in_tag = 4'h3;
        step();
        in_a = 8'h22; in_b = 8'hF0; in_tag = 4'h9; in_signed = 1'b1;
        step();
        out_ready = 1'b0;
        in_a = 8'h7F; in_b = 8'h81; in_tag = 4'hA;
        step();
        in_valid = 1'b0;
        repeat (2) step();
        out_ready = 1'b1;
        repeat (5) step();
        check("tag_count", tag_seen.size(), 3);
        if (tag_seen.size() == 3) begin
            check("tag_seq0", tag_seen[0], 4'h3);
            check("tag_seq1", tag_seen[1], 4'h9);
            check("tag_seq2", tag_seen[2], 4'hA);
        end
`endif

        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
